operand_fetch: RTL and testbench
================================

Name: operand_fetch

Overview:
- Read-side companion of the register file: accepts decoded instructions, drives the register file read addresses, captures operands into a one-entry output stage.
- Keeps a per-register busy scoreboard for writes not yet retired.
- Stalls on read-after-write hazards; forwards writeback data that lands on the same edge.
- Sits between decode and execute; snoops the same writeback bus (enable/address/data) that writes the register file.

Parameters:
ADDR_W, 4, register address width
DATA_W, 8, operand width
NUM_REGS, 16, scoreboard depth (2**ADDR_W)

Ports:
nclk  in  1  clock; all state updates on falling edge, same edge as register file write
reset  in  1  asynchronous, active-high
in_valid  in  1  decoded instruction present
in_ready  out  1  instruction accepted this edge when in_valid && in_ready
in_rs_a  in  ADDR_W  source A register
in_rs_b  in  ADDR_W  source B register
in_rd  in  ADDR_W  destination register
in_we  in  1  instruction will write in_rd
address_A  out  ADDR_W  register file read address A (combinational = in_rs_a)
address_B  out  ADDR_W  register file read address B (combinational = in_rs_b)
rf_data_A  in  DATA_W  register file read data A
rf_data_B  in  DATA_W  register file read data B
wb_enable  in  1  writeback strobe (same net as register file enable)
wb_address  in  ADDR_W  writeback register
wb_data  in  DATA_W  writeback value
out_valid  out  1  operand stage holds a valid instruction
out_ready  in  1  execute consumes stage
op_a  out  DATA_W  captured operand A
op_b  out  DATA_W  captured operand B
op_rd  out  ADDR_W  captured destination
op_we  out  1  captured write flag
stall  out  1  in_valid high but blocked by hazard

Behaviour:
- Reset: out_valid=0, op_a=op_b=0, op_rd=0, op_we=0, all busy bits=0. Reset mid-operation drops the held instruction and clears the scoreboard.
- Output stage free when !out_valid || out_ready.
- hazard_x (x = a, b): busy[in_rs_x] && !(wb_enable && wb_address==in_rs_x).
- in_ready = stage_free && !hazard_a && !hazard_b.
- stall = in_valid && stage_free && (hazard_a || hazard_b).
- Operand select for source x: wb_data if wb_enable && wb_address==in_rs_x, else rf_data_x.
- Accept edge: op_a/op_b/op_rd/op_we load; out_valid=1; if in_we then busy[in_rd] set.
- No accept, out_ready=1: out_valid=0; op_* hold last values.
- Scoreboard clear: wb_enable on the edge clears busy[wb_address]. Writeback to a non-busy register is legal and only updates data.
- Simultaneous set and clear of the same register on one edge: set wins.
- in_rd equal to a source: sources are evaluated against pre-edge busy state; the instruction does not stall on itself.
- Latency: accept to out_valid is one falling edge. Throughput is one instruction per edge when hazard-free and out_ready=1.
- No combinational path from out_ready to op_* data. in_ready does depend combinationally on out_ready, wb_*, and in_rs_*.

Optional Feature:
- Macro: OPERAND_FWD_BYPASS_EN.
- Defined: same-edge writeback forwarding as above.
- Undefined: hazard_x = busy[in_rs_x] regardless of wb_*. Operands always come from rf_data_x. A dependent instruction waits one extra edge until the register file holds the new value.

Test Plan:
- Reset, then issue rs_a=3, rs_b=5, we=0 with register file 3=6, 5=10 → one edge later out_valid=1, op_a=6, op_b=10, in_ready stays 1.
- Issue rd=4 we=1, then rs_a=4 with no writeback → stall=1, in_ready=0, op stage unchanged. Then wb_enable, wb_address=4, wb_data=0x55 → with FWD accept that edge, op_a=0x55. Without FWD, accept one edge later with op_a=0x55 from the register file.
- out_ready=0 with out_valid=1 and a new in_valid → in_ready=0, op_* hold. Raise out_ready → accept next edge.
- Issue rd=7 we=1 on the same edge as wb_address=7 wb_enable (retiring an older write) → busy[7] remains 1, so a following read of r7 stalls.
- Issue rd=2 we=1 with rs_a=2 while busy[2]=0 → no stall, op_a=4, busy[2]=1 afterwards.
- Assert reset while out_valid=1 and busy[9]=1 → immediately out_valid=0, busy cleared, read of r9 next cycle has no stall.

Source files
------------

// File: rtl/operand_fetch.sv
// Operand fetch stage: drives register file reads, tracks in-flight writes in a busy scoreboard and
// captures operands into a one-entry output stage. Define OPERAND_FWD_BYPASS_EN for same-edge writeback forwarding.
module operand_fetch #(
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 16
) (
  input  logic              nclk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_rs_a,
  input  logic [ADDR_W-1:0] in_rs_b,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic              in_we,
  output logic [ADDR_W-1:0] address_A,
  output logic [ADDR_W-1:0] address_B,
  input  logic [DATA_W-1:0] rf_data_A,
  input  logic [DATA_W-1:0] rf_data_B,
  input  logic              wb_enable,
  input  logic [ADDR_W-1:0] wb_address,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic [ADDR_W-1:0] op_rd,
  output logic              op_we,
  output logic              stall
);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   op_a_q, op_a_d;
  logic [DATA_W-1:0]   op_b_q, op_b_d;
  logic [ADDR_W-1:0]   op_rd_q, op_rd_d;
  logic                op_we_q, op_we_d;

  logic                fwd_a, fwd_b;
  logic                hazard_a, hazard_b;
  logic                stage_free, accept;
  logic [DATA_W-1:0]   sel_a, sel_b;

  function automatic logic [DATA_W-1:0] sel_operand(input logic              fwd,
                                                     input logic [DATA_W-1:0] wb,
                                                     input logic [DATA_W-1:0] rf);
    return fwd ? wb : rf;
  endfunction

  always_comb begin
    fwd_a = 1'b0;
    fwd_b = 1'b0;
`ifdef OPERAND_FWD_BYPASS_EN
    fwd_a = wb_enable && (wb_address == in_rs_a);
    fwd_b = wb_enable && (wb_address == in_rs_b);
`endif
  end

  // A source is blocked only while its pending write has not reached the register file or the bus.
  assign hazard_a   = busy_q[in_rs_a] && !fwd_a;
  assign hazard_b   = busy_q[in_rs_b] && !fwd_b;
  assign stage_free = !out_valid_q || out_ready;
  assign in_ready   = stage_free && !hazard_a && !hazard_b;
  assign stall      = in_valid && stage_free && (hazard_a || hazard_b);
  assign accept     = in_valid && in_ready;

  assign sel_a      = sel_operand(fwd_a, wb_data, rf_data_A);
  assign sel_b      = sel_operand(fwd_b, wb_data, rf_data_B);

  always_comb begin
    busy_d      = busy_q;
    out_valid_d = out_valid_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    op_rd_d     = op_rd_q;
    op_we_d     = op_we_q;
    if (accept) begin
      out_valid_d = 1'b1;
      op_a_d      = sel_a;
      op_b_d      = sel_b;
      op_rd_d     = in_rd;
      op_we_d     = in_we;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    // Clear first so a new claim on the same register in the same edge survives.
    if (wb_enable) busy_d[wb_address] = 1'b0;
    if (accept && in_we) busy_d[in_rd] = 1'b1;
  end

  always_ff @(negedge nclk or posedge reset) begin
    if (reset) begin
      busy_q      <= '0;
      out_valid_q <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_rd_q     <= '0;
      op_we_q     <= 1'b0;
    end else begin
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_rd_q     <= op_rd_d;
      op_we_q     <= op_we_d;
    end
  end

  assign address_A = in_rs_a;
  assign address_B = in_rs_b;
  assign out_valid = out_valid_q;
  assign op_a      = op_a_q;
  assign op_b      = op_b_q;
  assign op_rd     = op_rd_q;
  assign op_we     = op_we_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed scenarios plus randomized traffic against a behavioural model.
module tb_operand_fetch;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;

  logic              nclk;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_rs_a, in_rs_b, in_rd;
  logic              in_we;
  logic [ADDR_W-1:0] address_A, address_B;
  logic [DATA_W-1:0] rf_data_A, rf_data_B;
  logic              wb_enable;
  logic [ADDR_W-1:0] wb_address;
  logic [DATA_W-1:0] wb_data;
  logic              out_valid, out_ready;
  logic [DATA_W-1:0] op_a, op_b;
  logic [ADDR_W-1:0] op_rd;
  logic              op_we, stall;

  int n_cmp = 0;
  int n_fail = 0;

`ifdef OPERAND_FWD_BYPASS_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  operand_fetch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(16)) dut (
    .nclk(nclk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs_a(in_rs_a), .in_rs_b(in_rs_b), .in_rd(in_rd), .in_we(in_we),
    .address_A(address_A), .address_B(address_B),
    .rf_data_A(rf_data_A), .rf_data_B(rf_data_B),
    .wb_enable(wb_enable), .wb_address(wb_address), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .op_a(op_a), .op_b(op_b), .op_rd(op_rd), .op_we(op_we), .stall(stall)
  );

  initial nclk = 1'b1;
  always #5 nclk = ~nclk;

  // Register file environment: written on the same falling edge the DUT snoops.
  logic [DATA_W-1:0] rf [16];
  logic rf_init = 1'b0;
  always @(posedge rf_init or negedge nclk) begin
    if (rf_init) begin
      for (int i = 0; i < 16; i++) rf[i] <= DATA_W'(2 * i);
    end else if (wb_enable) begin
      rf[wb_address] <= wb_data;
    end
  end
  assign rf_data_A = rf[address_A];
  assign rf_data_B = rf[address_B];

  // Behavioural model: set of registers with an outstanding write, plus the held output instruction.
  bit [15:0]         m_pending = '0;
  bit                m_vld = 1'b0;
  logic [DATA_W-1:0] m_a = '0, m_b = '0;
  logic [ADDR_W-1:0] m_rd = '0;
  logic              m_we = 1'b0;
  logic              e_ready, e_stall, e_acc;
  logic [DATA_W-1:0] e_a, e_b;

  task automatic model_reset();
    m_pending = '0; m_vld = 1'b0; m_a = '0; m_b = '0; m_rd = '0; m_we = 1'b0;
  endtask

  // Settle inputs and predict the pre-edge outcome.
  task automatic settle();
    bit on_bus_a, on_bus_b, wait_a, wait_b, room;
    #1;
    room     = !m_vld || out_ready;
    on_bus_a = FWD && wb_enable && (wb_address == in_rs_a);
    on_bus_b = FWD && wb_enable && (wb_address == in_rs_b);
    wait_a   = m_pending[in_rs_a] && !on_bus_a;
    wait_b   = m_pending[in_rs_b] && !on_bus_b;
    e_a      = on_bus_a ? wb_data : rf[in_rs_a];
    e_b      = on_bus_b ? wb_data : rf[in_rs_b];
    e_ready  = room && !wait_a && !wait_b;
    e_stall  = in_valid && room && (wait_a || wait_b);
    e_acc    = in_valid && e_ready;
  endtask

  task automatic tick();
    settle();
    @(negedge nclk);
    if (e_acc) begin
      m_vld = 1'b1; m_a = e_a; m_b = e_b; m_rd = in_rd; m_we = in_we;
    end else if (out_ready) begin
      m_vld = 1'b0;
    end
    if (wb_enable) m_pending[wb_address] = 1'b0;
    if (e_acc && in_we) m_pending[in_rd] = 1'b1;
    #1;
  endtask

  task automatic issue(input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] rd, input logic we);
    in_valid = 1'b1; in_rs_a = ra; in_rs_b = rb; in_rd = rd; in_we = we;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_rs_a = '0; in_rs_b = '0; in_rd = '0; in_we = 1'b0;
    wb_enable = 1'b0; wb_address = '0; wb_data = '0; out_ready = 1'b1;
    #1 rf_init = 1'b1;
    #1 rf_init = 1'b0;
    @(negedge nclk); #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (op_a !== 8'h00 || op_b !== 8'h00) begin n_fail++; $display("FAIL reset_ops: got %h/%h want 00/00", op_a, op_b); end
    n_cmp++; if (op_rd !== 4'h0 || op_we !== 1'b0) begin n_fail++; $display("FAIL reset_rd_we: got %h/%b want 0/0", op_rd, op_we); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    @(posedge nclk); reset = 1'b0;
    model_reset();
  endtask

  task automatic test_basic();
    issue(4'd3, 4'd5, 4'd0, 1'b0);
    settle();
    n_cmp++; if (in_ready !== 1'b1 || stall !== 1'b0) begin n_fail++; $display("FAIL basic_ready: got ready=%b stall=%b want 1/0", in_ready, stall); end
    n_cmp++; if (address_A !== 4'd3 || address_B !== 4'd5) begin n_fail++; $display("FAIL basic_addr: got %h/%h want 3/5", address_A, address_B); end
    tick();
    n_cmp++; if (out_valid !== 1'b1 || op_a !== 8'd6 || op_b !== 8'd10) begin n_fail++; $display("FAIL basic_ops: got v=%b %0d/%0d want 1 6/10", out_valid, op_a, op_b); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready_after: got %b want 1", in_ready); end
    in_valid = 1'b0;
    tick();
    n_cmp++; if (out_valid !== 1'b0 || op_a !== 8'd6) begin n_fail++; $display("FAIL basic_drain: got v=%b a=%0d want 0 6", out_valid, op_a); end
  endtask

  task automatic test_raw_stall();
    issue(4'd0, 4'd0, 4'd4, 1'b1);
    tick();
    issue(4'd4, 4'd0, 4'd0, 1'b0);
    settle();
    n_cmp++; if (stall !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL raw_stall: got stall=%b ready=%b want 1/0", stall, in_ready); end
    tick();
    n_cmp++; if (out_valid !== 1'b0 || op_rd !== 4'd4 || op_we !== 1'b1) begin n_fail++; $display("FAIL raw_hold: got v=%b rd=%h we=%b want 0 4 1", out_valid, op_rd, op_we); end
    wb_enable = 1'b1; wb_address = 4'd4; wb_data = 8'h55;
    settle();
`ifdef OPERAND_FWD_BYPASS_EN
    n_cmp++; if (in_ready !== 1'b1 || stall !== 1'b0) begin n_fail++; $display("FAIL raw_fwd_ready: got ready=%b stall=%b want 1/0", in_ready, stall); end
    tick();
    wb_enable = 1'b0;
`else
    n_cmp++; if (in_ready !== 1'b0 || stall !== 1'b1) begin n_fail++; $display("FAIL raw_nofwd_wait: got ready=%b stall=%b want 0/1", in_ready, stall); end
    tick();
    wb_enable = 1'b0;
    settle();
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL raw_nofwd_ready: got %b want 1", in_ready); end
    tick();
`endif
    n_cmp++; if (out_valid !== 1'b1 || op_a !== 8'h55 || op_b !== 8'h00) begin n_fail++; $display("FAIL raw_ops: got v=%b %h/%h want 1 55/00", out_valid, op_a, op_b); end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    issue(4'd3, 4'd5, 4'd1, 1'b0);
    tick();
    out_ready = 1'b0;
    issue(4'd5, 4'd3, 4'd2, 1'b0);
    settle();
    n_cmp++; if (in_ready !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL bp_ready: got ready=%b stall=%b want 0/0", in_ready, stall); end
    tick();
    n_cmp++; if (out_valid !== 1'b1 || op_a !== 8'd6 || op_b !== 8'd10 || op_rd !== 4'd1) begin n_fail++; $display("FAIL bp_hold: got v=%b %0d/%0d rd=%0d want 1 6/10 1", out_valid, op_a, op_b, op_rd); end
    out_ready = 1'b1;
    settle();
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release: got %b want 1", in_ready); end
    tick();
    n_cmp++; if (op_a !== 8'd10 || op_b !== 8'd6 || op_rd !== 4'd2) begin n_fail++; $display("FAIL bp_next: got %0d/%0d rd=%0d want 10/6 2", op_a, op_b, op_rd); end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_set_clear_same();
    issue(4'd0, 4'd0, 4'd7, 1'b1);
    tick();
    issue(4'd0, 4'd1, 4'd7, 1'b1);
    wb_enable = 1'b1; wb_address = 4'd7; wb_data = 8'h77;
    settle();
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL setclr_accept: got %b want 1", in_ready); end
    tick();
    wb_enable = 1'b0;
    issue(4'd7, 4'd0, 4'd0, 1'b0);
    settle();
    n_cmp++; if (stall !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL setclr_still_busy: got stall=%b ready=%b want 1/0", stall, in_ready); end
    in_valid = 1'b0; wb_enable = 1'b1; wb_address = 4'd7; wb_data = 8'h77;
    tick();
    wb_enable = 1'b0;
  endtask

  task automatic test_self_dep();
    issue(4'd2, 4'd2, 4'd2, 1'b1);
    settle();
    n_cmp++; if (stall !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL self_nostall: got stall=%b ready=%b want 0/1", stall, in_ready); end
    tick();
    n_cmp++; if (op_a !== 8'd4 || op_b !== 8'd4 || op_rd !== 4'd2 || op_we !== 1'b1) begin n_fail++; $display("FAIL self_ops: got %0d/%0d rd=%0d we=%b want 4/4 2 1", op_a, op_b, op_rd, op_we); end
    issue(4'd2, 4'd0, 4'd0, 1'b0);
    settle();
    n_cmp++; if (stall !== 1'b1) begin n_fail++; $display("FAIL self_busy_after: got stall=%b want 1", stall); end
    in_valid = 1'b0; wb_enable = 1'b1; wb_address = 4'd2; wb_data = 8'd4;
    tick();
    wb_enable = 1'b0;
  endtask

  task automatic test_reset_mid();
    issue(4'd0, 4'd0, 4'd9, 1'b1);
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    tick();
    n_cmp++; if (out_valid !== 1'b1 || op_rd !== 4'd9) begin n_fail++; $display("FAIL rmid_pre: got v=%b rd=%0d want 1 9", out_valid, op_rd); end
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || op_rd !== 4'd0 || op_we !== 1'b0) begin n_fail++; $display("FAIL rmid_async: got v=%b rd=%0d we=%b want 0 0 0", out_valid, op_rd, op_we); end
    model_reset();
    #1 reset = 1'b0;
    out_ready = 1'b1;
    @(negedge nclk); #1;
    issue(4'd9, 4'd9, 4'd0, 1'b0);
    settle();
    n_cmp++; if (stall !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_cleared: got stall=%b ready=%b want 0/1", stall, in_ready); end
    tick();
    n_cmp++; if (op_a !== 8'd18 || op_b !== 8'd18) begin n_fail++; $display("FAIL rmid_ops: got %0d/%0d want 18/18", op_a, op_b); end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      in_rs_a    = 4'($urandom_range(0, 15));
      in_rs_b    = 4'($urandom_range(0, 15));
      in_rd      = 4'($urandom_range(0, 15));
      in_we      = ($urandom_range(0, 1) == 1);
      out_ready  = ($urandom_range(0, 3) != 0);
      wb_enable  = ($urandom_range(0, 2) == 0);
      wb_address = 4'($urandom_range(0, 15));
      wb_data    = 8'($urandom);
      settle();
      n_cmp++; if (in_ready !== e_ready || stall !== e_stall) begin n_fail++; $display("FAIL rnd_ctrl[%0d]: got ready=%b stall=%b want %b/%b", n, in_ready, stall, e_ready, e_stall); end
      tick();
      n_cmp++; if (out_valid !== m_vld || op_a !== m_a || op_b !== m_b || op_rd !== m_rd || op_we !== m_we) begin
        n_fail++;
        $display("FAIL rnd_stage[%0d]: got v=%b %h/%h rd=%h we=%b want v=%b %h/%h rd=%h we=%b", n, out_valid, op_a, op_b, op_rd, op_we, m_vld, m_a, m_b, m_rd, m_we);
      end
    end
    in_valid = 1'b0; wb_enable = 1'b0; out_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_raw_stall();
    test_backpressure();
    test_set_clear_same();
    test_self_dep();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
    $fatal(1, "timeout");
  end

endmodule
